rv_trace_monitor: RTL

//  Parametrised, synthesisable pipeline trace monitor for the Risc5CPU core.

---
 rtl/rv_trace_monitor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rv_trace_monitor.sv
// Pipeline trace monitor for the Risc5CPU core: circular PC/instruction
// trace, saturating performance counters, PC trigger and hang watchdog.
module rv_trace_monitor #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 16,
    parameter int CNT_W        = 32,
    parameter int HANG_CYCLES  = 64,
    parameter int STOP_ON_HANG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [XLEN-1:0]          PC,
    input  logic [XLEN-1:0]          Instruction_id,
    input  logic                     Stall,
    input  logic [1:0]               JumpFlag,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_instr,
    output logic [1:0]               rd_jump,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   trace_count,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic                     triggered,
    output logic                     hang,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HANG_CYCLES);
    localparam logic [AW:0]      FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    POST_LAST = AW'(DEPTH/2 - 1);
    localparam logic [HW-1:0]    RUN_ARM   = HW'(HANG_CYCLES - 2);
    localparam logic [HW-1:0]    RUN_MAX   = HW'(HANG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               STOP      = (STOP_ON_HANG != 0);

    typedef enum logic [1:0] {RUN, POST, DONE} state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [1:0]      mem_jump  [DEPTH];

    logic [AW-1:0]   wptr;
    logic [AW-1:0]   post_cnt;
    logic [AW-1:0]   rd_addr;
    logic [HW-1:0]   run_cnt;
    logic [XLEN-1:0] prev_pc;
    logic            prev_vld;

    logic active;
    logic capture;
    logic pc_same;
    logic trig_hit;
    logic hang_hit;
    logic post_end;
    logic rd_hit;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && v != CNT_MAX) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        active   = (state != DONE);
        capture  = active && !Stall;
        pc_same  = prev_vld && (PC == prev_pc);
        trig_hit = (state == RUN) && trig_en && !Stall && (PC == trig_pc);
        hang_hit = active && pc_same && (run_cnt == RUN_ARM);
        post_end = (state == POST) && capture && (post_cnt == POST_LAST);
        rd_addr  = wptr - trace_count[AW-1:0] + rd_idx;
        rd_hit   = ({1'b0, rd_idx} < trace_count);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      state <= RUN;
        else if (clear) state <= RUN;
        else            state <= state_nxt;
    end

    // A stopping hang wins over trigger so POST is skipped entirely.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (hang_hit && STOP) state_nxt = DONE;
                else if (trig_hit)    state_nxt = POST;
            end
            POST: begin
                if ((hang_hit && STOP) || post_end) state_nxt = DONE;
            end
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            trace_count <= '0;
            post_cnt    <= '0;
        end else if (clear) begin
            wptr        <= '0;
            trace_count <= '0;
            post_cnt    <= '0;
        end else if (capture) begin
            wptr <= wptr + 1'b1;
            if (trace_count != FULL) trace_count <= trace_count + 1'b1;
            if (state == POST)       post_cnt    <= post_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture && !clear) begin
            mem_pc[wptr]    <= PC;
            mem_instr[wptr] <= Instruction_id;
            mem_jump[wptr]  <= JumpFlag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (clear) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (active) begin
            cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
            stall_cnt  <= sat_inc(stall_cnt, Stall);
            flush_cnt  <= sat_inc(flush_cnt, JumpFlag != 2'b00);
            retire_cnt <= sat_inc(retire_cnt, !Stall);
        end
    end

    // Watchdog: run_cnt holds consecutive repeats of the previous PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt   <= '0;
            prev_pc   <= '0;
            prev_vld  <= 1'b0;
            triggered <= 1'b0;
            hang      <= 1'b0;
        end else if (clear) begin
            run_cnt   <= '0;
            prev_pc   <= '0;
            prev_vld  <= 1'b0;
            triggered <= 1'b0;
            hang      <= 1'b0;
        end else begin
            if (active) begin
                if (!pc_same)               run_cnt <= '0;
                else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
                prev_pc  <= PC;
                prev_vld <= 1'b1;
            end
            if (trig_hit) triggered <= 1'b1;
            if (hang_hit) hang      <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_pc    <= '0;
            rd_instr <= '0;
            rd_jump  <= '0;
        end else if (clear) begin
            rd_valid <= 1'b0;
            rd_pc    <= '0;
            rd_instr <= '0;
            rd_jump  <= '0;
        end else begin
            rd_valid <= rd_hit;
            rd_pc    <= rd_hit ? mem_pc[rd_addr]    : '0;
            rd_instr <= rd_hit ? mem_instr[rd_addr] : '0;
            rd_jump  <= rd_hit ? mem_jump[rd_addr]  : 2'b00;
        end
    end

endmodule
